// File: rtl/audio_writeback_pkg.sv
// Shared definitions for the audio line write-back path.
//   op_t        : DMA opcode driven on the op output.
//   state_t     : write-back FSM states.
//   LINE_BYTES  : bytes per line at the default 512-bit line width.
//   line_bytes  : pointer step in bytes for any line width.
package audio_writeback_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } op_t;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    REQ       = 2'b01,
    WAIT_DONE = 2'b10
  } state_t;

  localparam int DEFAULT_INW = 512;
  localparam int LINE_BYTES  = DEFAULT_INW / 8;

  function automatic int line_bytes(input int inw);
    return inw / 8;
  endfunction

endpackage

// File: rtl/audio_writeback_if.sv
// Signal bundle for the audio line write-back block.
//   master : side that produces audio lines and plays the DMA engine
//            (drives audio_valid/audio_in, base_load/base_addr,
//            dma_ready, tx_done; observes everything else).
//   slave  : the write-back block's view of the same wires.
//
// Handshakes:
//   audio   - a line transfers on a cycle where audio_valid && audio_ready;
//             audio_valid while audio_ready is low drops the line.
//   dma     - mem_write_en is a one-cycle request strobe; address and data
//             stay stable until the engine answers with a tx_done pulse.
interface audio_writeback_if #(
  parameter int INW   = 512,
  parameter int ADDRW = 32
);
  logic             audio_valid;
  logic [INW-1:0]   audio_in;
  logic             audio_ready;
  logic             base_load;
  logic [ADDRW-1:0] base_addr;
  logic             dma_ready;
  logic             tx_done;
  logic             mem_write_en;
  logic [1:0]       op;
  logic [ADDRW-1:0] mem_address;
  logic [INW-1:0]   common_data_bus_out;
  logic [15:0]      lines_written;
  logic             busy;
  logic             overflow;

  modport master (
    output audio_valid, audio_in, base_load, base_addr, dma_ready, tx_done,
    input  audio_ready, mem_write_en, op, mem_address, common_data_bus_out,
           lines_written, busy, overflow
  );

  modport slave (
    input  audio_valid, audio_in, base_load, base_addr, dma_ready, tx_done,
    output audio_ready, mem_write_en, op, mem_address, common_data_bus_out,
           lines_written, busy, overflow
  );

endinterface

// File: rtl/audio_writeback_sync_fifo.sv
// sync_fifo: single-clock FIFO holding whole audio lines.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO).
//   push/din : write din when push && !full.
//   pop/dout : dout is the head entry; pop removes it when !empty.
//   full, empty, count : occupancy at the start of the cycle.
// A push and a pop in the same cycle both happen and count is unchanged.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/audio_writeback.sv
// audio_writeback: buffers finished audio lines from the CPU and writes them
// one at a time to consecutive host addresses through a DMA engine.
//   clk, rst            : clock, synchronous active-high reset.
//   audio_valid/in/ready: line input; a line offered while not ready is
//                         dropped and sets the sticky overflow flag.
//   base_load/base_addr : reload the host write pointer (only when idle and
//                         the buffer is empty).
//   dma_ready, tx_done  : DMA engine handshake inputs.
//   mem_write_en, op, mem_address, common_data_bus_out : DMA request; the
//                         strobe lasts one cycle, address/data are held until
//                         tx_done.
//   lines_written       : saturating count of completed lines.
//   busy, overflow      : status.
// The FSM state is the internal signal 'state' (type state_t).
module audio_writeback
  import audio_writeback_pkg::*;
#(
  parameter int INW   = 512,
  parameter int ADDRW = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             audio_valid,
  input  logic [INW-1:0]   audio_in,
  output logic             audio_ready,
  input  logic             base_load,
  input  logic [ADDRW-1:0] base_addr,
  input  logic             dma_ready,
  input  logic             tx_done,
  output logic             mem_write_en,
  output logic [1:0]       op,
  output logic [ADDRW-1:0] mem_address,
  output logic [INW-1:0]   common_data_bus_out,
  output logic [15:0]      lines_written,
  output logic             busy,
  output logic             overflow
);

  localparam logic [ADDRW-1:0] LINE_STEP = ADDRW'(line_bytes(INW));

  state_t                  state;
  state_t                  next_state;
  logic [ADDRW-1:0]        ptr;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [INW-1:0]          fifo_head;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    start_req;

  sync_fifo #(
    .WIDTH (INW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (audio_in),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Readiness uses start-of-cycle occupancy, so a pop in this cycle does not
  // rescue a line offered against a full buffer.
  assign audio_ready = !fifo_full;
  assign fifo_push   = audio_valid && audio_ready;
  assign busy        = (state != IDLE) || (fifo_count != '0);

  always_comb begin
    next_state   = state;
    fifo_pop     = 1'b0;
    mem_write_en = 1'b0;
    op           = OP_NONE;
    case (state)
      IDLE: begin
        if (!fifo_empty && dma_ready) next_state = REQ;
      end
      REQ: begin
        mem_write_en = 1'b1;
        op           = OP_WRITE;
        next_state   = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          fifo_pop   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign start_req = (state == IDLE) && (next_state == REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      ptr                 <= '0;
      lines_written       <= '0;
      overflow            <= 1'b0;
      mem_address         <= '0;
      common_data_bus_out <= '0;
    end else begin
      state <= next_state;
      if (audio_valid && !audio_ready) overflow <= 1'b1;
      // Capture address and data on entry to REQ; they then stay put through
      // WAIT_DONE because neither the pointer nor the head can move until the
      // pop on tx_done.
      if (start_req) begin
        mem_address         <= ptr;
        common_data_bus_out <= fifo_head;
      end
      if (fifo_pop) begin
        ptr <= ptr + LINE_STEP;
        if (lines_written != 16'hFFFF) lines_written <= lines_written + 16'd1;
      end else if (base_load && (state == IDLE) && fifo_empty) begin
        ptr <= base_addr;
      end
    end
  end

endmodule

// File: tb/tb_audio_writeback.sv
// Directed bench for audio_writeback: six scenarios with hand-computed
// expected addresses, data and status values.
module tb_audio_writeback;
  import audio_writeback_pkg::*;

  localparam int INW   = 512;
  localparam int ADDRW = 32;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  audio_writeback_if #(.INW(INW), .ADDRW(ADDRW)) bus ();

  audio_writeback #(.INW(INW), .ADDRW(ADDRW), .DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .audio_valid         (bus.audio_valid),
    .audio_in            (bus.audio_in),
    .audio_ready         (bus.audio_ready),
    .base_load           (bus.base_load),
    .base_addr           (bus.base_addr),
    .dma_ready           (bus.dma_ready),
    .tx_done             (bus.tx_done),
    .mem_write_en        (bus.mem_write_en),
    .op                  (bus.op),
    .mem_address         (bus.mem_address),
    .common_data_bus_out (bus.common_data_bus_out),
    .lines_written       (bus.lines_written),
    .busy                (bus.busy),
    .overflow            (bus.overflow)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;
  logic [ADDRW-1:0] exp_q[$];
  logic [INW-1:0]   exp_d_q[$];

  always @(negedge clk) if (bus.mem_write_en === 1'b1) strobe_cnt++;

  task automatic check(input string tag, input logic [INW-1:0] got,
                       input logic [INW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [INW-1:0] pat(input logic [7:0] b);
    return {(INW/8){b}};
  endfunction

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    check("rst_we", bus.mem_write_en, 0);
    check("rst_op", bus.op, OP_NONE);
    check("rst_addr", bus.mem_address, 0);
    check("rst_data", bus.common_data_bus_out, 0);
    check("rst_lines", bus.lines_written, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    step();
    check("rst_ready", bus.audio_ready, 1);
  endtask

  task automatic load_base(input logic [ADDRW-1:0] a);
    bus.base_load = 1'b1;
    bus.base_addr = a;
    step();
    bus.base_load = 1'b0;
  endtask

  task automatic push_line(input logic [INW-1:0] d);
    bus.audio_valid = 1'b1;
    bus.audio_in    = d;
    step();
    bus.audio_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (bus.mem_write_en !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_strobe"}, bus.mem_write_en, 1);
  endtask

  // Serve one DMA write: check the request, then answer with tx_done so that
  // it is sampled 'delay' cycles after the strobe cycle (delay >= 1).
  task automatic service(input string tag, input logic [ADDRW-1:0] ea,
                         input logic [INW-1:0] ed, input int delay);
    wait_strobe(tag);
    check({tag, "_op"}, bus.op, OP_WRITE);
    check({tag, "_addr"}, bus.mem_address, ea);
    check({tag, "_data"}, bus.common_data_bus_out, ed);
    for (int i = 0; i < delay; i++) begin
      step();
      check({tag, "_wait_we"}, bus.mem_write_en, 0);
      check({tag, "_wait_op"}, bus.op, OP_NONE);
      check({tag, "_wait_addr"}, bus.mem_address, ea);
    end
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int s0;
    rst             = 1'b1;
    bus.audio_valid = 1'b0;
    bus.audio_in    = '0;
    bus.base_load   = 1'b0;
    bus.base_addr   = '0;
    bus.dma_ready   = 1'b0;
    bus.tx_done     = 1'b0;

    // 1: single line, tx_done 5 cycles after the strobe.
    do_reset();
    load_base(32'h1000);
    bus.dma_ready = 1'b1;
    s0 = strobe_cnt;
    push_line(pat(8'hA5));
    check("s1_busy", bus.busy, 1);
    service("s1", 32'h1000, pat(8'hA5), 5);
    check("s1_lines", bus.lines_written, 1);
    check("s1_busy_end", bus.busy, 0);
    check("s1_strobes", 32'(strobe_cnt - s0), 1);

    // 2: five back-to-back lines with DMA stalled; fifth is dropped.
    do_reset();
    load_base(32'h1000);
    bus.dma_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("s2_ready%0d", i), bus.audio_ready, (i < 4) ? 1 : 0);
      push_line(pat(8'(8'h10 + i)));
    end
    check("s2_ovf", bus.overflow, 1);
    check("s2_busy", bus.busy, 1);
    check("s2_no_we", bus.mem_write_en, 0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(32'h1000 + 32'(i * 64));
      exp_d_q.push_back(pat(8'(8'h10 + i)));
    end
    bus.dma_ready = 1'b1;
    while (exp_q.size() > 0) begin
      service("s2", exp_q.pop_front(), exp_d_q.pop_front(), 1);
    end
    check("s2_lines", bus.lines_written, 4);
    check("s2_busy_end", bus.busy, 0);

    // 3: offer a line against a full FIFO in the pop cycle.
    do_reset();
    load_base(32'h2000);
    bus.dma_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_line(pat(8'(8'h31 + i)));
    bus.dma_ready = 1'b1;
    wait_strobe("s3a");
    check("s3a_addr", bus.mem_address, 32'h2000);
    step();
    bus.tx_done     = 1'b1;
    bus.audio_valid = 1'b1;
    bus.audio_in    = pat(8'hEE);
    check("s3_full_ready", bus.audio_ready, 0);
    step();
    bus.tx_done     = 1'b0;
    bus.audio_valid = 1'b0;
    check("s3_ovf", bus.overflow, 1);
    check("s3_lines1", bus.lines_written, 1);
    check("s3_ready_after", bus.audio_ready, 1);
    push_line(pat(8'h77));
    service("s3b", 32'h2040, pat(8'h32), 1);
    service("s3c", 32'h2080, pat(8'h33), 2);
    service("s3d", 32'h20C0, pat(8'h34), 1);
    service("s3e", 32'h2100, pat(8'h77), 1);
    check("s3_lines", bus.lines_written, 5);

    // 4: pointer wrap.
    do_reset();
    load_base(32'hFFFF_FFC0);
    bus.dma_ready = 1'b1;
    push_line(pat(8'h5A));
    push_line(pat(8'hC3));
    service("s4a", 32'hFFFF_FFC0, pat(8'h5A), 1);
    service("s4b", 32'h0000_0000, pat(8'hC3), 1);
    check("s4_lines", bus.lines_written, 2);

    // 5: reset during WAIT_DONE, then a late tx_done.
    do_reset();
    bus.dma_ready = 1'b1;
    push_line(pat(8'h99));
    wait_strobe("s5");
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.tx_done = 1'b1;
    s0 = strobe_cnt;
    step();
    bus.tx_done = 1'b0;
    step();
    step();
    check("s5_lines", bus.lines_written, 0);
    check("s5_busy", bus.busy, 0);
    check("s5_addr", bus.mem_address, 0);
    check("s5_data", bus.common_data_bus_out, 0);
    check("s5_op", bus.op, OP_NONE);
    check("s5_ovf", bus.overflow, 0);
    check("s5_ready", bus.audio_ready, 1);
    check("s5_no_strobe", 32'(strobe_cnt - s0), 0);

    // 6: stray tx_done in IDLE; base_load while busy is ignored.
    load_base(32'h3000);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    check("s6_lines0", bus.lines_written, 0);
    check("s6_busy0", bus.busy, 0);
    bus.dma_ready = 1'b0;
    push_line(pat(8'h66));
    load_base(32'h5000);
    bus.dma_ready = 1'b1;
    wait_strobe("s6a");
    load_base(32'h7000);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    check("s6_addr", bus.mem_address, 32'h3000);
    check("s6_lines1", bus.lines_written, 1);
    push_line(pat(8'h67));
    service("s6b", 32'h3040, pat(8'h67), 1);
    check("s6_lines2", bus.lines_written, 2);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/audio_writeback.md
AUDIO_WRITEBACK -- requirements
Module: audio_writeback

Interface
REQ-001 SHALL have parameter INW, default 512, meaning audio line / DMA data width in bits.
REQ-002 SHALL have parameter ADDRW, default 32, meaning host byte-address width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning line-buffer entries (power of two, >=2).
REQ-004 SHALL have ports, in this order:
  clk  in  1  sole clock, all state updates on rising edge.
  rst  in  1  reset; one clock, reset is synchronous and active-high.
  audio_valid  in  1  CPU presents a finished audio line this cycle.
  audio_in  in  INW  audio line from CPU audio_out.
  audio_ready  out  1  buffer can accept a line this cycle.
  base_load  in  1  load host write pointer.
  base_addr  in  ADDRW  new host write pointer (byte address).
  dma_ready  in  1  DMA engine can accept a request.
  tx_done  in  1  DMA engine finished the outstanding write.
  mem_write_en  out  1  one-cycle DMA write request strobe.
  op  out  2  DMA opcode.
  mem_address  out  ADDRW  host byte address of the line being written.
  common_data_bus_out  out  INW  line being written, held until tx_done.
  lines_written  out  16  completed-line counter.
  busy  out  1  buffer non-empty or write outstanding.
  overflow  out  1  sticky: a line was dropped.

Function
REQ-005 SHALL buffer lines in a DEPTH-entry FIFO; audio_ready = 1 when FIFO count < DEPTH at the start of the cycle.
REQ-006 SHALL push audio_in when audio_valid && audio_ready; push is visible to the FSM the following cycle.
REQ-007 SHALL, on audio_valid && !audio_ready, drop the line and set overflow (held until rst), even if a pop occurs in the same cycle.
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT_DONE.
REQ-009 IDLE -> REQ when FIFO non-empty && dma_ready; otherwise stay in IDLE.
REQ-010 REQ lasts exactly one cycle and drives mem_write_en=1, op=OP_WRITE, mem_address=pointer, common_data_bus_out=FIFO head; then moves to WAIT_DONE.
REQ-011 WAIT_DONE holds mem_address and common_data_bus_out stable with mem_write_en=0, op=OP_NONE; on tx_done it pops the head, adds 64 (INW/8) to the pointer, increments lines_written, and returns to IDLE.
REQ-012 SHALL ignore tx_done in IDLE and REQ.
REQ-013 Minimum line-to-line spacing SHALL be 3 cycles (REQ, WAIT_DONE with tx_done, IDLE).
REQ-014 Pointer SHALL wrap modulo 2^ADDRW; lines_written SHALL saturate at 0xFFFF.
REQ-015 base_load SHALL take effect only in IDLE with the FIFO empty; otherwise it is ignored.
REQ-016 Simultaneous push and pop SHALL both take effect; count is unchanged.
REQ-017 busy = (state != IDLE) || FIFO non-empty.
REQ-018 op SHALL be OP_NONE in all cycles except REQ.

Reset
REQ-019 When rst is high at a clock edge: state=IDLE, FIFO empty, pointer=0, lines_written=0, overflow=0, mem_write_en=0, op=OP_NONE, mem_address=0, common_data_bus_out=0. audio_ready is 1 from the first cycle after reset.
REQ-020 rst asserted in REQ or WAIT_DONE SHALL abandon the outstanding write and discard all buffered lines; a later tx_done SHALL be ignored.

Structure
REQ-021 A shared package SHALL hold the op_t encoding (OP_NONE=2'b00, OP_READ=2'b01, OP_WRITE=2'b10), the FSM state enum, and LINE_BYTES=INW/8.
REQ-022 The FIFO SHALL be a separate sub-module, sync_fifo (parameters WIDTH and DEPTH; push, pop, full, empty, count), with the FSM and pointer logic in audio_writeback.

Verification
REQ-023 Scenario 1: reset, base_load with base_addr=0x1000 in IDLE, push one line of 0xA5 pattern, dma_ready=1, tx_done 5 cycles after the strobe -> one mem_write_en pulse, mem_address=0x1000, data=pattern, lines_written=1, busy=0.
REQ-024 Scenario 2: dma_ready=0, push 5 lines back-to-back -> audio_ready falls after the 4th line, the 5th is dropped, overflow=1; release dma_ready -> 4 writes at 0x1000, 0x1040, 0x1080, 0x10C0.
REQ-025 Scenario 3: full FIFO with a pop in the same cycle as audio_valid -> line dropped and overflow set; the next cycle's push is accepted.
REQ-026 Scenario 4: pointer=0xFFFFFFC0, two lines -> addresses 0xFFFFFFC0 then 0x00000000.
REQ-027 Scenario 5: rst during WAIT_DONE, then tx_done pulse -> lines_written stays 0, no pop, all outputs at reset values.
REQ-028 Scenario 6: stray tx_done in IDLE, and base_load while busy -> no state change; the pointer keeps its old value.
